interrupt_control_mc: RTL and testbench
=======================================

Name: interrupt_control_mc

Overview:
Multi-channel successor to the single-DMA interrupt gate. It collects NUM_SRC interrupt sources, such as DMA engines and timers. Each source has a software-programmable enable mask and a per-source trigger mode (level or rising-edge). Pending requests are arbitrated by fixed priority and presented to the CPU as one INTR with a source ID. An in-service FSM blocks new requests until the CPU signals end-of-interrupt (EOI).

Parameters:
C_M_AXI_DATA_WIDTH, 32, width of the register write data bus.
NUM_SRC, 4, number of interrupt sources; legal range 1..C_M_AXI_DATA_WIDTH.
ID_WIDTH, 2, width of the source ID; must be at least clog2(NUM_SRC) and at least 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
mask_write  input  1  one-cycle strobe; load the enable register from wdata[NUM_SRC-1:0].
mode_write  input  1  one-cycle strobe; load the trigger-mode register from wdata[NUM_SRC-1:0] (1 = edge, 0 = level).
wdata  input  C_M_AXI_DATA_WIDTH  register write data.
src_intr  input  NUM_SRC  raw source requests, synchronous to clk.
src_entr  output  NUM_SRC  one-hot acknowledge pulse back to the granted source.
pending  output  NUM_SRC  current pending vector, for software status read.
INTR  output  1  interrupt request to the CPU.
intr_id  output  ID_WIDTH  ID of the requested or in-service source.
ENTR  input  1  CPU accepts the interrupt (interrupt entry).
EOI  input  1  CPU finishes the handler (end of interrupt).

Behaviour:
- Reset values:
  - enable = 0, mode = 0, edge-capture register = 0, src_d = 0.
  - FSM = IDLE, intr_id = 0.
  - INTR = 0, src_entr = 0, pending = 0.
- Writes:
  - mask_write and mode_write take effect on the next edge.
  - Bits of wdata at index NUM_SRC and above are ignored.
  - Both strobes may be asserted in the same cycle.
- Source sampling:
  - src_d is a registered copy of src_intr.
  - A rising edge is detected when src_intr=1 and src_d=0.
- Edge-mode pending:
  - A detected edge sets the capture bit on the next clock edge.
  - The bit clears when that source is acknowledged.
  - If a new edge and the acknowledge occur in the same cycle, the bit stays set (the new edge wins).
- Level-mode pending: follows src_intr combinationally; the capture bit is unused.
- pending[i] = enable[i] & (mode[i] ? capture[i] : src_intr[i]).
- Arbitration: fixed priority, lowest index wins. It is evaluated only in IDLE.
- FSM states and transitions:
  - IDLE: if any pending bit is set, latch the winning ID into intr_id and go to REQ.
  - REQ: INTR = 1.
    - If ENTR=1: pulse src_entr[intr_id] for exactly that cycle, clear capture[intr_id] if the source is edge mode, and go to SERVICE.
    - Else if pending[intr_id]=0 (masked or level dropped): go to IDLE. INTR falls on the next edge; no src_entr pulse.
  - SERVICE: INTR = 0 and no new request is raised.
    - EOI=1: go to IDLE.
    - Sources that become pending during SERVICE are held and arbitrated after return to IDLE.
- INTR and intr_id are registered, derived from the FSM state; src_entr is a combinational decode of ENTR in REQ.
- Latency:
  - Source asserts at edge n; capture/pending is visible after edge n+1.
  - FSM enters REQ and INTR=1 after edge n+2. This applies to both modes.
  - Minimum back-to-back spacing: EOI in cycle k allows INTR again from cycle k+2.
- intr_id stays stable from entry to REQ until return to IDLE.
- Ignored inputs: ENTR outside REQ, EOI outside SERVICE.
  - If ENTR and EOI are both high in REQ, only ENTR acts.
- Masking a source while it is in SERVICE does not abort service.
  - Its capture bit is still cleared on acknowledge.
- rst asserted at any time forces the reset values immediately, including mid-service.
- NUM_SRC=1: intr_id is constant 0; the FSM still applies.

Decomposition:
- Shared package (intr_pkg):
  - FSM state encoding IDLE/REQ/SERVICE, 2 bits.
  - Trigger-mode constants MODE_LEVEL=0, MODE_EDGE=1.
  - The clog2 helper function.
- One sub-module, intr_prio_enc: a combinational fixed-priority encoder (NUM_SRC to ID_WIDTH plus a valid flag).
- Everything else (capture, registers, FSM) lives in the top module.

Test Plan:
- Reset, then mask=0x1 and mode=0; hold src_intr[0]=1 → INTR=1 and intr_id=0 two cycles later. ENTR pulse → src_entr=0001 for one cycle, FSM in SERVICE, INTR=0. EOI → INTR=1 again two cycles later, because the level is still high.
- mask=0xF, mode=0xF; pulse src_intr[3] and src_intr[1] for one cycle in the same cycle → intr_id=1 first. After ENTR and EOI, intr_id=3. pending goes 1010 → 1000 → 0000.
- Edge source 2 acknowledged by ENTR in the same cycle a new src_intr[2] edge is detected → capture[2] remains 1; a second request for ID 2 follows EOI.
- In REQ, clear the mask via mask_write with wdata=0 → INTR drops on the following edge, FSM returns to IDLE, src_entr stays 0. A later ENTR is ignored.
- Assert rst asynchronously (mid-cycle) during SERVICE with capture=0xF → all outputs 0 immediately, before the next clock edge. After release, no request until registers are reprogrammed.
- ENTR in IDLE and EOI in REQ → no state change and src_entr=0.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the multi-channel interrupt controller.
//   - intr_state_e : in-service FSM encoding (IDLE / REQ / SERVICE), 2 bits
//   - MODE_LEVEL / MODE_EDGE : trigger-mode register bit values
//   - clog2 : elaboration-time ceiling log2 for sizing source IDs
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest-index set bit of req wins.
// Ports:
//   req   [NUM_SRC]  request vector
//   id    [ID_WIDTH] index of the winning request (0 when none)
//   valid            at least one request is set
module intr_prio_enc #(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]  req,
  output logic [ID_WIDTH-1:0] id,
  output logic                valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    // Scan from the top down so the last hit, the lowest index, sticks.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_WIDTH'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_control_mc.sv
// Multi-channel interrupt controller. Collects NUM_SRC sources, each with a
// software enable bit and a level/rising-edge trigger mode, arbitrates the
// pending ones by fixed priority and presents one request (INTR + intr_id)
// to the CPU. An in-service FSM holds off new requests until EOI.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   mask_write, wdata     load enable register from wdata[NUM_SRC-1:0]
//   mode_write, wdata     load trigger-mode register (1 = edge, 0 = level)
//   src_intr              raw source requests, synchronous to clk
//   src_entr              one-hot acknowledge to the granted source
//   pending               pending vector for software status
//   INTR, intr_id         registered request and source ID to the CPU
//   ENTR, EOI             CPU interrupt entry / end of interrupt
module interrupt_control_mc
  import intr_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_SRC            = 4,
  parameter int ID_WIDTH           = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mask_write,
  input  logic                          mode_write,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wdata,
  input  logic [NUM_SRC-1:0]            src_intr,
  output logic [NUM_SRC-1:0]            src_entr,
  output logic [NUM_SRC-1:0]            pending,
  output logic                          INTR,
  output logic [ID_WIDTH-1:0]           intr_id,
  input  logic                          ENTR,
  input  logic                          EOI
);

  logic [NUM_SRC-1:0]  enable;
  logic [NUM_SRC-1:0]  mode;
  logic [NUM_SRC-1:0]  capture;
  logic [NUM_SRC-1:0]  src_d;
  logic [NUM_SRC-1:0]  edge_det;
  logic [NUM_SRC-1:0]  id_sel;
  logic [NUM_SRC-1:0]  ack_clr;
  logic [ID_WIDTH-1:0] win_id;
  logic                win_valid;
  logic                ack;
  logic                id_pending;
  intr_state_e         state;

  // Write-data bits above the source count carry no meaning here.
  if (NUM_SRC < C_M_AXI_DATA_WIDTH) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[C_M_AXI_DATA_WIDTH-1:NUM_SRC];
  end

  // Edges are only remembered for sources in edge mode.
  assign edge_det = src_intr & ~src_d & mode;

  assign pending  = enable & ((mode & capture) | (~mode & src_intr));

  assign id_sel     = NUM_SRC'(1) << intr_id;
  assign id_pending = |(pending & id_sel);
  assign ack        = (state == REQ) && ENTR;
  assign src_entr   = ack ? id_sel : '0;
  // Acknowledge clears the granted bit; a simultaneous new edge re-sets it.
  assign ack_clr    = ack ? (id_sel & mode) : '0;

  intr_prio_enc #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio_enc (
    .req   (pending),
    .id    (win_id),
    .valid (win_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable  <= '0;
      mode    <= '0;
      capture <= '0;
      src_d   <= '0;
    end else begin
      if (mask_write) enable <= wdata[NUM_SRC-1:0];
      if (mode_write) mode   <= wdata[NUM_SRC-1:0];
      capture <= (capture & ~ack_clr) | edge_det;
      src_d   <= src_intr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      intr_id <= '0;
      INTR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            intr_id <= win_id;
            state   <= REQ;
            INTR    <= 1'b1;
          end
        end
        REQ: begin
          if (ENTR) begin
            state <= SERVICE;
            INTR  <= 1'b0;
          end else if (!id_pending) begin
            // Request withdrawn (masked or level dropped) before entry.
            state <= IDLE;
            INTR  <= 1'b0;
          end
        end
        SERVICE: begin
          if (EOI) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          INTR  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_control_mc.sv
// Self-checking bench for interrupt_control_mc. A cycle model pushes the
// expected outputs of each cycle to a queue when the stimulus is driven; a
// monitor pops and compares them on the falling edge. Directed checks
// against fixed values cover the scenario milestones.
module tb_interrupt_control_mc;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mask_write, mode_write;
  logic [W-1:0]  wdata;
  logic [N-1:0]  src_intr;
  logic [N-1:0]  src_entr;
  logic [N-1:0]  pending;
  logic          INTR;
  logic [IW-1:0] intr_id;
  logic          ENTR, EOI;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [N-1:0]  pending;
    logic [N-1:0]  src_entr;
    logic          intr;
    logic [IW-1:0] id;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [N-1:0] m_en, m_mode, m_cap, m_srcd;
  logic [1:0]   m_state;
  int           m_id;

  interrupt_control_mc #(
    .C_M_AXI_DATA_WIDTH (W),
    .NUM_SRC            (N),
    .ID_WIDTH           (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mask_write (mask_write),
    .mode_write (mode_write),
    .wdata      (wdata),
    .src_intr   (src_intr),
    .src_entr   (src_entr),
    .pending    (pending),
    .INTR       (INTR),
    .intr_id    (intr_id),
    .ENTR       (ENTR),
    .EOI        (EOI)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_cap = '0; m_srcd = '0;
    m_state = S_IDLE; m_id = 0;
  endtask

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++)
      p[i] = m_en[i] && (m_mode[i] ? m_cap[i] : src_intr[i]);
    return p;
  endfunction

  task automatic model_expect(output exp_t e);
    e.pending  = model_pending();
    e.src_entr = (m_state == S_REQ && ENTR) ? N'(1 << m_id) : '0;
    e.intr     = (m_state == S_REQ);
    e.id       = IW'(m_id);
  endtask

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_step();
    logic [N-1:0] p, cap_n;
    int win;
    p = model_pending();
    cap_n = m_cap;
    if (m_state == S_REQ && ENTR && m_mode[m_id]) cap_n[m_id] = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_mode[i] && src_intr[i] && !m_srcd[i]) cap_n[i] = 1'b1;
    case (m_state)
      S_IDLE: begin
        win = -1;
        for (int i = 0; i < N; i++)
          if (p[i] && win < 0) win = i;
        if (win >= 0) begin
          m_id = win;
          m_state = S_REQ;
        end
      end
      S_REQ: begin
        if (ENTR) m_state = S_SERV;
        else if (!p[m_id]) m_state = S_IDLE;
      end
      default: if (EOI) m_state = S_IDLE;
    endcase
    if (mask_write) m_en = wdata[N-1:0];
    if (mode_write) m_mode = wdata[N-1:0];
    m_cap = cap_n;
    m_srcd = src_intr;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_pending", 32'(pending), 32'(e.pending));
      check("sb_src_entr", 32'(src_entr), 32'(e.src_entr));
      check("sb_intr", 32'(INTR), 32'(e.intr));
      check("sb_intr_id", 32'(intr_id), 32'(e.id));
    end
  end

  task automatic cyc();
    exp_t e;
    model_expect(e);
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input logic [N-1:0] s, input logic en, input logic eo);
    src_intr = s; ENTR = en; EOI = eo;
    mask_write = 1'b0; mode_write = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic mw, input logic modw, input logic [W-1:0] wd,
                    input logic [N-1:0] s);
    src_intr = s; ENTR = 1'b0; EOI = 1'b0;
    mask_write = mw; mode_write = modw; wdata = wd;
    cyc();
    mask_write = 1'b0; mode_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mask_write = 1'b0; mode_write = 1'b0; wdata = '0;
    src_intr = '0; ENTR = 1'b0; EOI = 1'b0;
    model_reset();
    #1;
    check("rst_intr", 32'(INTR), 0);
    check("rst_src_entr", 32'(src_entr), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_intr_id", 32'(intr_id), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(4'b0000, 0, 0);

    // Level source 0
    wr(1, 0, 32'h1, 4'b0001);
    step(4'b0001, 0, 0);
    check("t1_intr_up", 32'(INTR), 1);
    check("t1_id", 32'(intr_id), 0);
    ENTR = 1'b1; #1;
    check("t1_entr_pulse", 32'(src_entr), 32'h1);
    step(4'b0001, 1, 0);
    check("t1_service_intr", 32'(INTR), 0);
    step(4'b0001, 0, 1);
    step(4'b0001, 0, 0);
    check("t1_rerequest", 32'(INTR), 1);
    step(4'b0001, 1, 0);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    // Edge sources 3 and 1 pulsed together
    wr(1, 1, 32'hF, 4'b0000);
    step(4'b1010, 0, 0);
    check("t2_pending_1010", 32'(pending), 32'hA);
    step(4'b0000, 0, 0);
    check("t2_first_id", 32'(intr_id), 1);
    step(4'b0000, 1, 0);
    check("t2_pending_1000", 32'(pending), 32'h8);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);
    check("t2_second_id", 32'(intr_id), 3);
    check("t2_second_intr", 32'(INTR), 1);
    step(4'b0000, 1, 0);
    check("t2_pending_0000", 32'(pending), 0);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    // New edge on source 2 coincides with its acknowledge
    step(4'b0100, 0, 0);
    step(4'b0000, 0, 0);
    check("t3_id", 32'(intr_id), 2);
    step(4'b0100, 1, 0);
    check("t3_new_edge_wins", 32'(pending), 32'h4);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);
    check("t3_second_req", 32'(INTR), 1);
    check("t3_second_id", 32'(intr_id), 2);
    step(4'b0000, 1, 0);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    // Mask cleared while in REQ
    step(4'b0010, 0, 0);
    step(4'b0000, 0, 0);
    check("t4_req", 32'(INTR), 1);
    wr(1, 0, 32'h0, 4'b0000);
    step(4'b0000, 0, 0);
    check("t4_intr_dropped", 32'(INTR), 0);
    ENTR = 1'b1; #1;
    check("t4_entr_idle_ignored", 32'(src_entr), 0);
    step(4'b0000, 1, 0);
    check("t4_still_idle", 32'(INTR), 0);

    // Unmask: held capture[1] requests again; EOI in REQ is ignored
    wr(1, 0, 32'hF, 4'b0000);
    step(4'b0000, 0, 0);
    check("t6_req_id", 32'(intr_id), 1);
    step(4'b0000, 0, 1);
    check("t6_eoi_in_req", 32'(INTR), 1);
    step(4'b0001, 1, 1);
    check("t6_entr_wins", 32'(INTR), 0);
    step(4'b0000, 0, 0);
    check("t6_held_in_service", 32'(INTR), 0);
    check("t6_held_pending", 32'(pending), 32'h1);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);
    check("t6_held_served", 32'(intr_id), 0);
    step(4'b0000, 1, 0);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);

    // Asynchronous reset during SERVICE with all captures set
    step(4'b1111, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0001, 1, 0);
    step(4'b0000, 0, 0);
    check("t5_capture_full", 32'(pending), 32'hF);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_intr", 32'(INTR), 0);
    check("t5_rst_pending", 32'(pending), 0);
    check("t5_rst_src_entr", 32'(src_entr), 0);
    check("t5_rst_id", 32'(intr_id), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 0);
    step(4'b1111, 0, 0);
    check("t5_no_req_after_rst", 32'(INTR), 0);
    wr(1, 0, 32'h1, 4'b1111);
    step(4'b1111, 0, 0);
    check("t5_reprogrammed", 32'(INTR), 1);
    step(4'b1111, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
